// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle controller for a 4 x 4-bit register file.
// One request reads up to two source registers, computes a 4-bit result
// and writes it back to the destination register. The register-file bus
// (address, write data, strobe) comes straight from flops, so the value
// for the next state is computed here and registered on the state change.

module alu_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] op,
  input  logic [1:0] src_a,
  input  logic [1:0] src_b,
  input  logic [1:0] dst,
  input  logic [3:0] imm,
  output logic       busy,
  output logic       done,
  output logic [3:0] result,
  output logic       carry,
  output logic       zero,
  output logic [1:0] mem_addr,
  output logic [3:0] mem_dbus,
  output logic       mem_rwb,
  input  logic [3:0] mem_qout
);

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_SUB   = 2'b01;
  localparam logic [1:0] OP_AND   = 2'b10;
  localparam logic [1:0] OP_LOADI = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    READ_A,
    READ_B,
    EXEC,
    WRITE,
    DONE
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] op_q, op_d;
  logic [1:0] src_b_q, src_b_d;
  logic [1:0] dst_q, dst_d;
  logic [3:0] imm_q, imm_d;
  logic [3:0] opa_q, opa_d;
  logic [3:0] opb_q, opb_d;
  logic [3:0] result_q, result_d;
  logic       carry_q, carry_d;
  logic       zero_q, zero_d;
  logic [1:0] mem_addr_q, mem_addr_d;
  logic [3:0] mem_dbus_q, mem_dbus_d;
  logic       mem_rwb_q, mem_rwb_d;
  logic [4:0] sum;
  logic [4:0] diff;

  // Next-state logic; bus values are prepared for the state being entered.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    src_b_d    = src_b_q;
    dst_d      = dst_q;
    imm_d      = imm_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    result_d   = result_q;
    carry_d    = carry_q;
    zero_d     = zero_q;
    mem_addr_d = mem_addr_q;
    mem_dbus_d = mem_dbus_q;
    mem_rwb_d  = 1'b0;
    sum        = {1'b0, opa_q} + {1'b0, opb_q};
    diff       = {1'b0, opa_q} - {1'b0, opb_q};

    case (state_q)
      IDLE: begin
        if (start) begin
          op_d    = op;
          src_b_d = src_b;
          dst_d   = dst;
          imm_d   = imm;
          if (op == OP_LOADI) begin
            state_d = EXEC;
          end else begin
            state_d    = READ_A;
            mem_addr_d = src_a;
          end
        end
      end
      READ_A: begin
        opa_d      = mem_qout;
        mem_addr_d = src_b_q;
        state_d    = READ_B;
      end
      READ_B: begin
        opb_d   = mem_qout;
        state_d = EXEC;
      end
      EXEC: begin
        case (op_q)
          OP_ADD: begin
            result_d = sum[3:0];
            carry_d  = sum[4];
          end
          OP_SUB: begin
            result_d = diff[3:0];
            carry_d  = diff[4];
          end
          OP_AND: begin
            result_d = opa_q & opb_q;
            carry_d  = 1'b0;
          end
          default: begin
            result_d = imm_q;
            carry_d  = 1'b0;
          end
        endcase
        zero_d     = (result_d == 4'd0);
        mem_addr_d = dst_q;
        mem_dbus_d = result_d;
        mem_rwb_d  = 1'b1;
        state_d    = WRITE;
      end
      WRITE: begin
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, operand, result and register-file bus registers with sync reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      op_q       <= 2'd0;
      src_b_q    <= 2'd0;
      dst_q      <= 2'd0;
      imm_q      <= 4'd0;
      opa_q      <= 4'd0;
      opb_q      <= 4'd0;
      result_q   <= 4'd0;
      carry_q    <= 1'b0;
      zero_q     <= 1'b0;
      mem_addr_q <= 2'd0;
      mem_dbus_q <= 4'd0;
      mem_rwb_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      src_b_q    <= src_b_d;
      dst_q      <= dst_d;
      imm_q      <= imm_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      result_q   <= result_d;
      carry_q    <= carry_d;
      zero_q     <= zero_d;
      mem_addr_q <= mem_addr_d;
      mem_dbus_q <= mem_dbus_d;
      mem_rwb_q  <= mem_rwb_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign result   = result_q;
  assign carry    = carry_q;
  assign zero     = zero_q;
  assign mem_addr = mem_addr_q;
  assign mem_dbus = mem_dbus_q;
  assign mem_rwb  = mem_rwb_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Testbench for alu_sequencer: a behavioural 4 x 4-bit register file is
// attached to the bus, requests are issued (directed then random), and a
// scoreboard monitor checks every write strobe and done pulse.

module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [1:0] op;
  logic [1:0] src_a;
  logic [1:0] src_b;
  logic [1:0] dst;
  logic [3:0] imm;
  logic       busy;
  logic       done;
  logic [3:0] result;
  logic       carry;
  logic       zero;
  logic [1:0] mem_addr;
  logic [3:0] mem_dbus;
  logic       mem_rwb;
  logic [3:0] mem_qout;

  typedef struct {
    int dst;
    int res;
    int cy;
    int z;
    int doneCycle;
  } exp_t;

  exp_t       expQ[$];
  logic [3:0] regs [0:3] = '{4'd0, 4'd0, 4'd0, 4'd0};
  logic [3:0] gold [0:3];
  int         tests = 0;
  int         fails = 0;
  int         cycleCount = 0;
  int         writesSeen = 0;

  alu_sequencer dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .src_a    (src_a),
    .src_b    (src_b),
    .dst      (dst),
    .imm      (imm),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .carry    (carry),
    .zero     (zero),
    .mem_addr (mem_addr),
    .mem_dbus (mem_dbus),
    .mem_rwb  (mem_rwb),
    .mem_qout (mem_qout)
  );

  always #5 clk = ~clk;

  // Cycle counter used to time done pulses against the issue edge.
  always @(posedge clk) cycleCount <= cycleCount + 1;

  // Register file model: combinational read, write on strobe.
  always @(posedge clk) if (mem_rwb) regs[mem_addr] <= mem_dbus;
  assign mem_qout = regs[mem_addr];

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Reference behaviour of one operation in plain integer arithmetic.
  function automatic void refModel(input int o, input int a, input int b, input int im,
                                   output int res, output int cy);
    int s;
    case (o)
      0: begin s = a + b; res = s % 16; cy = (s > 15) ? 1 : 0; end
      1: begin res = (a - b + 16) % 16; cy = (a < b) ? 1 : 0; end
      2: begin res = a & b; cy = 0; end
      default: begin res = im; cy = 0; end
    endcase
  endfunction

  function automatic logic [15:0] packGold();
    return {gold[3], gold[2], gold[1], gold[0]};
  endfunction

  // Scoreboard monitor: checks write strobes and done pulses at negedge.
  always @(negedge clk) begin
    if (reset !== 1'b1) begin
      if (mem_rwb === 1'b1) begin
        writesSeen++;
        if (expQ.size() == 0) begin
          checkOutput("unexpected_write", 16'd1, 16'd0);
        end else begin
          checkOutput("write_addr", 16'(mem_addr), 16'(expQ[0].dst));
          checkOutput("write_data", 16'(mem_dbus), 16'(expQ[0].res));
        end
      end
      if (done === 1'b1) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_done", 16'd1, 16'd0);
        end else begin
          exp_t x;
          x = expQ.pop_front();
          checkOutput("result", 16'(result), 16'(x.res));
          checkOutput("carry", 16'(carry), 16'(x.cy));
          checkOutput("zero", 16'(zero), 16'(x.z));
          checkOutput("done_cycle", 16'(cycleCount), 16'(x.doneCycle));
          checkOutput("write_pulses", 16'(writesSeen), 16'd1);
          checkOutput("regfile", {regs[3], regs[2], regs[1], regs[0]}, packGold());
        end
        writesSeen = 0;
      end
    end
  end

  // Waits (bounded) until the sequencer is idle; returns at a negedge.
  task automatic waitIdle();
    int n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) checkOutput("idle_timeout", 16'(busy), 16'd0);
  endtask

  // Issues one request, pushing its expected outcome; returns issue edge.
  task automatic applyStimulus(input int o, input int sa, input int sb, input int d,
                               input int im, input bit commit, output int e);
    int res, cy;
    waitIdle();
    refModel(o, gold[sa], gold[sb], im, res, cy);
    e = cycleCount + 1;
    expQ.push_back('{d, res, cy, (res == 0) ? 1 : 0, e + ((o == 3) ? 2 : 4)});
    if (commit) gold[d] = 4'(res);
    start = 1'b1;
    op = 2'(o); src_a = 2'(sa); src_b = 2'(sb); dst = 2'(d); imm = 4'(im);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_busy"}, 16'(busy), 16'd0);
    checkOutput({tag, "_done"}, 16'(done), 16'd0);
    checkOutput({tag, "_result"}, 16'(result), 16'd0);
    checkOutput({tag, "_carry"}, 16'(carry), 16'd0);
    checkOutput({tag, "_zero"}, 16'(zero), 16'd0);
    checkOutput({tag, "_addr"}, 16'(mem_addr), 16'd0);
    checkOutput({tag, "_dbus"}, 16'(mem_dbus), 16'd0);
    checkOutput({tag, "_rwb"}, 16'(mem_rwb), 16'd0);
  endtask

  // Issues an operation, then asserts reset for 2 cycles after k cycles.
  task automatic resetMidOp(input int o, input int sa, input int sb, input int d,
                            input int im, input int k);
    int e, res, cy, resetEdge;
    refModel(o, gold[sa], gold[sb], im, res, cy);
    applyStimulus(o, sa, sb, d, im, 1'b0, e);
    repeat (k) @(negedge clk);
    reset = 1'b1;
    resetEdge = cycleCount + 1;
    @(negedge clk);
    @(negedge clk);
    checkAllZero("midreset");
    expQ.delete();
    writesSeen = 0;
    if (resetEdge >= e + ((o == 3) ? 2 : 4)) gold[d] = 4'(res);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("regfile_after_reset", {regs[3], regs[2], regs[1], regs[0]}, packGold());
  endtask

  // Start held high through an ADD: second request is taken only in IDLE.
  task automatic heldStart();
    int e, res1, cy1, res2, cy2;
    waitIdle();
    refModel(0, gold[1], gold[2], 0, res1, cy1);
    e = cycleCount + 1;
    expQ.push_back('{3, res1, cy1, (res1 == 0) ? 1 : 0, e + 4});
    gold[3] = 4'(res1);
    start = 1'b1; op = 2'd0; src_a = 2'd1; src_b = 2'd2; dst = 2'd3; imm = 4'd0;
    @(negedge clk);
    op = 2'd2; src_a = 2'd1; src_b = 2'd2; dst = 2'd0; imm = 4'd0;
    refModel(2, gold[1], gold[2], 0, res2, cy2);
    expQ.push_back('{0, res2, cy2, (res2 == 0) ? 1 : 0, e + 6 + 4});
    while (cycleCount < e + 5) @(negedge clk);
    gold[0] = 4'(res2);
    while (cycleCount < e + 6) @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int e;
    for (int i = 0; i < 4; i++) gold[i] = 4'd0;
    reset = 1'b1; start = 1'b0; op = 2'd0; src_a = 2'd0; src_b = 2'd0; dst = 2'd0; imm = 4'd0;
    repeat (2) @(negedge clk);
    checkAllZero("reset");
    reset = 1'b0;

    applyStimulus(3, 0, 0, 1, 7, 1'b1, e);
    applyStimulus(3, 0, 0, 2, 9, 1'b1, e);
    waitIdle();
    checkOutput("r1_loadi", 16'(regs[1]), 16'd7);
    checkOutput("r2_loadi", 16'(regs[2]), 16'd9);

    applyStimulus(0, 1, 2, 3, 0, 1'b1, e);
    waitIdle();
    checkOutput("add_result", 16'(result), 16'd0);
    checkOutput("add_carry", 16'(carry), 16'd1);
    checkOutput("add_zero", 16'(zero), 16'd1);
    checkOutput("r3_add", 16'(regs[3]), 16'd0);

    applyStimulus(1, 1, 2, 0, 0, 1'b1, e);
    waitIdle();
    checkOutput("sub_result", 16'(result), 16'd14);
    checkOutput("sub_carry", 16'(carry), 16'd1);
    checkOutput("sub_zero", 16'(zero), 16'd0);
    applyStimulus(2, 0, 1, 0, 0, 1'b1, e);
    waitIdle();
    checkOutput("and_result", 16'(result), 16'd6);
    checkOutput("and_carry", 16'(carry), 16'd0);

    heldStart();
    waitIdle();
    checkOutput("held_start_drained", 16'(expQ.size()), 16'd0);

    applyStimulus(3, 0, 0, 3, 5, 1'b1, e);
    resetMidOp(0, 1, 2, 3, 0, 1);
    checkOutput("r3_after_abort", 16'(regs[3]), 16'd5);

    for (int i = 0; i < 40; i++) begin
      int o;
      o = int'($urandom_range(0, 3));
      if (i % 10 == 9) begin
        resetMidOp(o, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
                   int'($urandom_range(0, (o == 3) ? 1 : 3)));
      end else begin
        applyStimulus(o, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 15)), 1'b1, e);
      end
    end

    waitIdle();
    repeat (2) @(negedge clk);
    checkOutput("queue_drained", 16'(expQ.size()), 16'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
